// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks post-decode stage metadata and issues
// stall/bubble/flush plus ID-stage and EX-aligned forwarding selects.
module pipe_hazard_ctrl #(
   parameter int unsigned REG_AW      = 4,
   parameter int unsigned NUM_STAGES  = 3,
   parameter int unsigned LOAD_LAT    = 2,
   parameter bit          ZERO_REG_EN = 1'b1,
   parameter int unsigned STALL_CNT_W = 16,
   localparam int unsigned FSEL_W     = $clog2(NUM_STAGES + 1)
) (
   input  logic                   clk,
   input  logic                   pc_reset_n,
   input  logic                   id_valid,
   input  logic [REG_AW-1:0]      id_rs,
   input  logic [REG_AW-1:0]      id_rt,
   input  logic                   id_uses_rs,
   input  logic                   id_uses_rt,
   input  logic                   id_early,
   input  logic [REG_AW-1:0]      id_rd,
   input  logic                   id_reg_write,
   input  logic                   id_mem_read,
   input  logic                   branch_taken,
   output logic                   stall,
   output logic                   bubble,
   output logic                   if_id_nop,
   output logic [FSEL_W-1:0]      id_fwd_a,
   output logic [FSEL_W-1:0]      id_fwd_b,
   output logic [FSEL_W-1:0]      ex_fwd_a,
   output logic [FSEL_W-1:0]      ex_fwd_b,
   output logic [STALL_CNT_W-1:0] stall_count
);

   // Stage tracker, index 0 = EX, NUM_STAGES-1 = WB
   logic [NUM_STAGES-1:0]             vld_q, vld_d;
   logic [NUM_STAGES-1:0]             wr_q, wr_d;
   logic [NUM_STAGES-1:0]             ld_q, ld_d;
   logic [NUM_STAGES-1:0][REG_AW-1:0] rd_q, rd_d;

   logic [FSEL_W-1:0]      ex_fwd_a_q, ex_fwd_a_d;
   logic [FSEL_W-1:0]      ex_fwd_b_q, ex_fwd_b_d;
   logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

   // Operand 0 = rs (A), operand 1 = rt (B)
   logic [1:0][REG_AW-1:0] op;
   logic [1:0]             op_use;
   logic [1:0]             op_hit;
   logic [1:0]             op_ld;
   logic [1:0]             op_stall;
   int unsigned            op_dist [2];
   logic [1:0][FSEL_W-1:0] op_id_fwd;
   logic [1:0][FSEL_W-1:0] op_ex_sel;

   assign op     = {id_rt, id_rs};
   assign op_use = {id_uses_rt, id_uses_rs};

   // Find the youngest in-flight producer of each operand
   always_comb begin
      op_hit = '0;
      op_ld  = '0;
      for (int o = 0; o < 2; o++) begin
         op_dist[o] = 0;
         for (int unsigned j = 0; j < NUM_STAGES; j++) begin
            if (!op_hit[o] && vld_q[j] && wr_q[j] && op_use[o] && (rd_q[j] == op[o]) &&
                !(ZERO_REG_EN && (op[o] == '0))) begin
               op_hit[o]  = 1'b1;
               op_ld[o]   = ld_q[j];
               op_dist[o] = j;
            end
         end
      end
   end

   // Readiness per operand and the resulting forwarding selects
   always_comb begin
      op_stall  = '0;
      op_id_fwd = '0;
      op_ex_sel = '0;
      for (int o = 0; o < 2; o++) begin
         if (op_hit[o]) begin
            if (id_early) begin
               op_stall[o] = op_ld[o] && (op_dist[o] < LOAD_LAT);
               if (!op_stall[o]) begin
                  op_id_fwd[o] = FSEL_W'(op_dist[o] + 1);
               end
            end else begin
               op_stall[o] = op_ld[o] && (op_dist[o] + 1 < LOAD_LAT);
               // Producer leaving the pipe is picked up by the write-first regfile
               if (op_dist[o] + 1 <= NUM_STAGES - 1) begin
                  op_ex_sel[o] = FSEL_W'(op_dist[o] + 1);
               end
            end
         end
      end
   end

   // Control outputs; stall overrides a taken branch, which re-resolves later
   always_comb begin
      stall       = id_valid & (|op_stall);
      bubble      = stall;
      if_id_nop   = branch_taken & ~stall;
      id_fwd_a    = op_id_fwd[0];
      id_fwd_b    = op_id_fwd[1];
      ex_fwd_a    = ex_fwd_a_q;
      ex_fwd_b    = ex_fwd_b_q;
      stall_count = stall_count_q;
   end

   // Next state: shift tracker, insert ID or a bubble, latch EX selects, count stalls
   always_comb begin
      vld_d = {vld_q[NUM_STAGES-2:0], id_valid & ~stall};
      wr_d  = {wr_q[NUM_STAGES-2:0], id_reg_write};
      ld_d  = {ld_q[NUM_STAGES-2:0], id_mem_read};
      rd_d  = {rd_q[NUM_STAGES-2:0], id_rd};

      ex_fwd_a_d = '0;
      ex_fwd_b_d = '0;
      if (~stall & id_valid & ~id_early) begin
         ex_fwd_a_d = op_ex_sel[0];
         ex_fwd_b_d = op_ex_sel[1];
      end

      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + STALL_CNT_W'(1);
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge pc_reset_n) begin
      if (!pc_reset_n) begin
         vld_q         <= '0;
         wr_q          <= '0;
         ld_q          <= '0;
         rd_q          <= '0;
         ex_fwd_a_q    <= '0;
         ex_fwd_b_q    <= '0;
         stall_count_q <= '0;
      end else begin
         vld_q         <= vld_d;
         wr_q          <= wr_d;
         ld_q          <= ld_d;
         rd_q          <= rd_d;
         ex_fwd_a_q    <= ex_fwd_a_d;
         ex_fwd_b_q    <= ex_fwd_b_d;
         stall_count_q <= stall_count_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a timestamp-based model of in-flight producers.
module tb_pipe_hazard_ctrl;

   localparam int NS = 3;
   localparam int LL = 2;

   logic       clk = 1'b0;
   logic       pc_reset_n;
   logic       id_valid, id_uses_rs, id_uses_rt, id_early, id_reg_write, id_mem_read;
   logic       branch_taken;
   logic [3:0] id_rs, id_rt, id_rd;
   logic       stall, bubble, if_id_nop;
   logic [1:0] id_fwd_a, id_fwd_b, ex_fwd_a, ex_fwd_b;
   logic [15:0] stall_count;
   logic       stall2, bubble2, if_id_nop2;
   logic [1:0] id_fwd_a2, id_fwd_b2, ex_fwd_a2, ex_fwd_b2;
   logic [1:0] stall_count2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk(clk), .pc_reset_n(pc_reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_early(id_early), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
      .stall(stall), .bubble(bubble), .if_id_nop(if_id_nop), .id_fwd_a(id_fwd_a),
      .id_fwd_b(id_fwd_b), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .stall_count(stall_count)
   );

   pipe_hazard_ctrl #(.STALL_CNT_W(2)) dut2 (
      .clk(clk), .pc_reset_n(pc_reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_early(id_early), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
      .stall(stall2), .bubble(bubble2), .if_id_nop(if_id_nop2), .id_fwd_a(id_fwd_a2),
      .id_fwd_b(id_fwd_b2), .ex_fwd_a(ex_fwd_a2), .ex_fwd_b(ex_fwd_b2),
      .stall_count(stall_count2)
   );

   // Reference model: issued instructions stamped with their issue edge; age = stage index
   typedef struct {
      int         t;
      logic [3:0] rd;
      logic       wr;
      logic       ld;
   } ins_t;

   ins_t        hist[$];
   int          now;
   logic        exp_stall;
   logic [1:0]  exp_idf_a, exp_idf_b, exs_a, exs_b, exp_ex_a, exp_ex_b;
   logic [15:0] exp_cnt;

   task automatic model_clear();
      hist.delete();
      now      = 0;
      exp_ex_a = 2'd0;
      exp_ex_b = 2'd0;
      exp_cnt  = 16'd0;
   endtask

   task automatic model_op(input logic [3:0] r, input logic u, output logic st,
                           output logic [1:0] idf, output logic [1:0] exs);
      int   d;
      logic ld;
      d   = -1;
      ld  = 1'b0;
      st  = 1'b0;
      idf = 2'd0;
      exs = 2'd0;
      if (u && r != 4'd0) begin
         for (int i = hist.size() - 1; i >= 0; i--) begin
            if (d < 0 && hist[i].wr && hist[i].rd == r && (now - hist[i].t) < NS) begin
               d  = now - hist[i].t;
               ld = hist[i].ld;
            end
         end
      end
      if (d >= 0) begin
         if (id_early) begin
            st = ld && (d < LL);
            if (!st) idf = 2'(d + 1);
         end else begin
            st = ld && (d + 1 < LL);
            if (d + 1 < NS) exs = 2'(d + 1);
         end
      end
   endtask

   task automatic eval();
      logic sa, sb;
      model_op(id_rs, id_uses_rs, sa, exp_idf_a, exs_a);
      model_op(id_rt, id_uses_rt, sb, exp_idf_b, exs_b);
      exp_stall = id_valid && (sa || sb);
   endtask

   task automatic set_ins(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                          input logic urs, input logic urt, input logic early,
                          input logic [3:0] rd, input logic wr, input logic ld,
                          input logic br);
      id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      id_early = early; id_rd = rd; id_reg_write = wr; id_mem_read = ld; branch_taken = br;
      eval();
      #1;
   endtask

   task automatic idle();
      set_ins(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      logic iss;
      ins_t e;
      iss = id_valid && !exp_stall;
      e.rd = id_rd; e.wr = id_reg_write; e.ld = id_mem_read;
      exp_ex_a = (!exp_stall && id_valid && !id_early) ? exs_a : 2'd0;
      exp_ex_b = (!exp_stall && id_valid && !id_early) ? exs_b : 2'd0;
      if (exp_stall && exp_cnt != 16'hffff) exp_cnt++;
      @(posedge clk);
      now++;
      if (iss) begin
         e.t = now;
         hist.push_back(e);
      end
      while (hist.size() > 0 && (now - hist[0].t) >= NS) void'(hist.pop_front());
      #1;
   endtask

   task automatic do_reset();
      pc_reset_n = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      pc_reset_n = 1'b1;
   endtask

   task automatic test_reset();
      pc_reset_n = 1'b0;
      idle();
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", stall); end
      n_checks++; if (ex_fwd_a !== 2'd0 || ex_fwd_b !== 2'd0) begin n_fail++; $display("FAIL reset_ex_fwd got %0d/%0d want 0/0", ex_fwd_a, ex_fwd_b); end
      n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", stall_count); end
      n_checks++; if (id_fwd_a !== 2'd0 || id_fwd_b !== 2'd0) begin n_fail++; $display("FAIL reset_id_fwd got %0d/%0d want 0/0", id_fwd_a, id_fwd_b); end
      do_reset();
   endtask

   task automatic test_alu_fwd();
      do_reset();
      set_ins(1, 4'd9, 4'd10, 0, 0, 0, 4'd1, 1, 0, 0); tick();
      set_ins(1, 4'd1, 4'd2, 1, 0, 0, 4'd3, 1, 0, 0);
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_nostall got %0b want 0", stall); end
      tick(); idle();
      n_checks++; if (ex_fwd_a !== 2'd1) begin n_fail++; $display("FAIL alu_ex_fwd1 got %0d want 1", ex_fwd_a); end
      set_ins(1, 4'd9, 4'd10, 0, 0, 0, 4'd1, 1, 0, 0); tick();
      set_ins(1, 4'd6, 4'd7, 1, 1, 0, 4'd5, 1, 0, 0); tick();
      set_ins(1, 4'd1, 4'd2, 1, 0, 0, 4'd3, 1, 0, 0);
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_gap_nostall got %0b want 0", stall); end
      tick(); idle();
      n_checks++; if (ex_fwd_a !== 2'd2) begin n_fail++; $display("FAIL alu_ex_fwd2 got %0d want 2", ex_fwd_a); end
   endtask

   task automatic test_load_use();
      do_reset();
      set_ins(1, 4'd0, 4'd0, 0, 0, 0, 4'd2, 1, 1, 0); tick();
      set_ins(1, 4'd4, 4'd2, 1, 1, 0, 4'd6, 1, 0, 0);
      n_checks++; if (stall !== 1'b1 || bubble !== 1'b1) begin n_fail++; $display("FAIL ld_use_stall got %0b/%0b want 1/1", stall, bubble); end
      tick();
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ld_use_release got %0b want 0", stall); end
      tick(); idle();
      n_checks++; if (ex_fwd_b !== 2'd2 || ex_fwd_a !== 2'd0) begin n_fail++; $display("FAIL ld_use_ex_fwd got b=%0d a=%0d want b=2 a=0", ex_fwd_b, ex_fwd_a); end
      n_checks++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL ld_use_count got %0d want 1", stall_count); end
   endtask

   task automatic test_early_load();
      do_reset();
      set_ins(1, 4'd0, 4'd0, 0, 0, 0, 4'd3, 1, 1, 0); tick();
      set_ins(1, 4'd3, 4'd0, 1, 0, 1, 4'd0, 0, 0, 0);
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL early_stall1 got %0b want 1", stall); end
      tick();
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL early_stall2 got %0b want 1", stall); end
      tick();
      n_checks++; if (stall !== 1'b0 || id_fwd_a !== 2'd3) begin n_fail++; $display("FAIL early_fwd got stall=%0b fwd=%0d want 0/3", stall, id_fwd_a); end
      tick(); idle();
      n_checks++; if (stall_count !== 16'd2 || ex_fwd_a !== 2'd0) begin n_fail++; $display("FAIL early_count got %0d ex=%0d want 2/0", stall_count, ex_fwd_a); end
   endtask

   task automatic test_zero_reg();
      do_reset();
      set_ins(1, 4'd5, 4'd6, 0, 0, 0, 4'd0, 1, 0, 0); tick();
      set_ins(1, 4'd0, 4'd0, 1, 1, 0, 4'd7, 1, 0, 0);
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_nostall got %0b want 0", stall); end
      tick(); idle();
      n_checks++; if (ex_fwd_a !== 2'd0 || ex_fwd_b !== 2'd0) begin n_fail++; $display("FAIL zero_ex_fwd got %0d/%0d want 0/0", ex_fwd_a, ex_fwd_b); end
      set_ins(1, 4'd5, 4'd6, 0, 0, 0, 4'd0, 1, 1, 0); tick();
      set_ins(1, 4'd0, 4'd0, 1, 1, 1, 4'd0, 0, 0, 0);
      n_checks++; if (stall !== 1'b0 || id_fwd_a !== 2'd0 || id_fwd_b !== 2'd0) begin n_fail++; $display("FAIL zero_early got stall=%0b fwd=%0d/%0d want 0/0/0", stall, id_fwd_a, id_fwd_b); end
      tick();
   endtask

   task automatic test_branch();
      do_reset();
      set_ins(1, 4'd7, 4'd0, 1, 0, 1, 4'd0, 0, 0, 1);
      n_checks++; if (if_id_nop !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL br_flush got nop=%0b stall=%0b want 1/0", if_id_nop, stall); end
      tick();
      set_ins(1, 4'd0, 4'd0, 0, 0, 0, 4'd4, 1, 1, 0); tick();
      set_ins(1, 4'd4, 4'd0, 1, 0, 1, 4'd0, 0, 0, 1);
      n_checks++; if (if_id_nop !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL br_stalled got nop=%0b stall=%0b want 0/1", if_id_nop, stall); end
      tick();
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_ins(1, 4'd0, 4'd0, 0, 0, 0, 4'd2, 1, 1, 0); tick();
      set_ins(1, 4'd4, 4'd2, 1, 1, 0, 4'd6, 1, 0, 0); tick(); tick();
      set_ins(1, 4'd8, 4'd9, 0, 0, 0, 4'd5, 1, 0, 0); tick();
      set_ins(1, 4'd5, 4'd0, 1, 0, 0, 4'd3, 1, 1, 0); tick();
      set_ins(1, 4'd3, 4'd0, 1, 0, 1, 4'd0, 0, 0, 0);
      n_checks++; if (stall !== 1'b1 || ex_fwd_a !== 2'd1 || stall_count !== 16'd1) begin n_fail++; $display("FAIL pre_reset got stall=%0b ex=%0d cnt=%0d want 1/1/1", stall, ex_fwd_a, stall_count); end
      pc_reset_n = 1'b0;
      #1;
      n_checks++; if (stall !== 1'b0 || ex_fwd_a !== 2'd0 || ex_fwd_b !== 2'd0) begin n_fail++; $display("FAIL async_reset got stall=%0b ex=%0d/%0d want 0/0/0", stall, ex_fwd_a, ex_fwd_b); end
      n_checks++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL async_reset_count got %0d want 0", stall_count); end
      model_clear();
      @(posedge clk);
      #1;
      pc_reset_n = 1'b1;
   endtask

   task automatic test_saturate();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         set_ins(1, 4'd0, 4'd0, 0, 0, 0, 4'd3, 1, 1, 0); tick();
         set_ins(1, 4'd3, 4'd0, 1, 0, 1, 4'd0, 0, 0, 0);
         repeat (3) tick();
      end
      set_ins(1, 4'd0, 4'd0, 0, 0, 0, 4'd2, 1, 1, 0); tick();
      set_ins(1, 4'd4, 4'd2, 1, 1, 0, 4'd6, 1, 0, 0);
      repeat (2) tick();
      idle(); tick();
      n_checks++; if (stall_count !== 16'd5) begin n_fail++; $display("FAIL sat_wide_count got %0d want 5", stall_count); end
      n_checks++; if (stall_count2 !== 2'd3) begin n_fail++; $display("FAIL sat_narrow_count got %0d want 3", stall_count2); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         set_ins($urandom_range(0, 3) != 0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 7) == 0);
         n_checks++; if (stall !== exp_stall || bubble !== exp_stall) begin n_fail++; $display("FAIL rnd_stall c=%0d got %0b/%0b want %0b", c, stall, bubble, exp_stall); end
         n_checks++; if (if_id_nop !== (branch_taken && !exp_stall)) begin n_fail++; $display("FAIL rnd_nop c=%0d got %0b want %0b", c, if_id_nop, branch_taken && !exp_stall); end
         n_checks++; if (id_fwd_a !== exp_idf_a || id_fwd_b !== exp_idf_b) begin n_fail++; $display("FAIL rnd_id_fwd c=%0d got %0d/%0d want %0d/%0d", c, id_fwd_a, id_fwd_b, exp_idf_a, exp_idf_b); end
         n_checks++; if (ex_fwd_a !== exp_ex_a || ex_fwd_b !== exp_ex_b) begin n_fail++; $display("FAIL rnd_ex_fwd c=%0d got %0d/%0d want %0d/%0d", c, ex_fwd_a, ex_fwd_b, exp_ex_a, exp_ex_b); end
         n_checks++; if (stall_count !== exp_cnt) begin n_fail++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, stall_count, exp_cnt); end
         tick();
      end
   endtask

   initial begin
      pc_reset_n = 1'b0;
      model_clear();
      test_reset();
      test_alu_fwd();
      test_load_use();
      test_early_load();
      test_zero_reg();
      test_branch();
      test_reset_mid_stall();
      test_saturate();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
